stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
- Round-robin arbiter that lets NREQ requesters share one LIFO stack instance. Sits between requester blocks and the stack.
- Grants one push or pop per cycle and drives the stack push/pop enables.
- Returns a registered response to the granted requester one cycle later: pop data, or an error for push-when-full or pop-when-empty.

Parameters:
NREQ, 4, number of requesters (2..16); index width IW = $clog2(NREQ)
DW, 32, data width; must equal the shared stack's data width

Ports:
clk  input  1  clock
areset  input  1  reset; one clock; reset is asynchronous and active-high
i_req  input  NREQ  per-requester request valid; held until granted
i_op  input  NREQ  per-requester operation: 1 = push, 0 = pop
i_wdata  input  NREQ*DW  per-requester push data, flattened; requester k uses bits [k*DW +: DW]
o_gnt  output  NREQ  one-hot grant, combinational; request k is accepted when i_req[k] & o_gnt[k]
o_rsp_vld  output  NREQ  one-hot response strobe, registered, one cycle after grant
o_rsp_err  output  1  response error: push rejected (full) or pop rejected (empty); valid with o_rsp_vld
o_rsp_data  output  DW  popped data; valid with o_rsp_vld for a successful pop, else holds last value
o_stk_push_en  output  1  to stack push enable
o_stk_push_data  output  DW  to stack push data
o_stk_pop_en  output  1  to stack pop enable
i_stk_pop_data  input  DW  stack top-of-stack data (combinational)
i_stk_full  input  1  stack full flag
i_stk_empty  input  1  stack empty flag

Behaviour:
- Reset (async, areset = 1):
  - last_gnt_ff = NREQ-1, so requester 0 has first priority.
  - o_rsp_vld = 0, o_rsp_err = 0, o_rsp_data = 0.
  - Combinational outputs are 0 while no request is present.
- Arbitration:
  - Search order is last_gnt_ff+1, +2, ... wrapping modulo NREQ; the first asserted i_req wins.
  - At most one o_gnt bit per cycle; o_gnt = 0 when i_req = 0.
  - On any grant, last_gnt_ff <= winner index. No grant leaves last_gnt_ff unchanged.
- Arbitration is work-conserving: a grant issues every cycle any request is pending, including requests that will be rejected.
- Stack drive, for winner w in the same cycle as the grant:
  - Push and not i_stk_full: o_stk_push_en = 1, o_stk_push_data = i_wdata[w].
  - Pop and not i_stk_empty: o_stk_pop_en = 1.
  - Rejected operation: both enables 0, no stack state change.
  - o_stk_push_en and o_stk_pop_en are never both 1.
  - o_stk_push_data = 0 when o_stk_push_en = 0.
- Response, registered at the grant edge and visible in cycle T+1 for a grant in cycle T:
  - o_rsp_vld = one-hot of w for exactly one cycle.
  - Successful pop: o_rsp_err = 0 and o_rsp_data = i_stk_pop_data sampled in cycle T, i.e. the item removed.
  - Successful push: o_rsp_err = 0 and o_rsp_data unchanged.
  - Rejected operation: o_rsp_err = 1 and o_rsp_data unchanged.
  - With no grant in cycle T: o_rsp_vld = 0 and o_rsp_err = 0 in T+1.
- Back-to-back grants:
  - Responses pipeline at one per cycle; no bubbles.
  - A grant in T and T+1 to the same requester is allowed only if it re-requests after acceptance.
  - The stack flags seen in T+1 already reflect the operation from T.
- Fairness: with all NREQ requesting continuously, each is granted exactly once in every NREQ consecutive cycles.
- Reset mid-operation:
  - A pending response is dropped (o_rsp_vld forced 0).
  - The arbiter does not reset the stack; the integrator drives the stack reset from the same source.
- Illegal inputs: i_op and i_wdata are don't-care while the matching i_req = 0.

Test Plan:
- Reset, all i_req = 0 -> o_gnt = 0000, o_rsp_vld = 0000, both stack enables 0.
- NREQ = 4, DW = 8, empty 4-deep stack. Req0 pushes 0xA1, then Req1 pushes 0xB2 -> o_stk_push_en pulses with 0xA1 then 0xB2; o_rsp_vld = 0001, then 0010, both with err = 0.
- Following on, Req2 pops -> grant in T; o_rsp_vld = 0100 in T+1 with o_rsp_data = 0xB2 and err = 0. A second pop returns 0xA1.
- All four requesters continuously request pops while the stack is empty -> o_gnt sequence 0001, 0010, 0100, 1000, 0001; every response has err = 1; o_stk_pop_en stays 0.
- Stack holds 4 items (full), Req3 pushes 0x55 -> grant issued, o_stk_push_en = 0, o_rsp_vld = 1000 with err = 1, stack contents unchanged. Then Req0 pops -> data = 4th item pushed.
- areset asserted the cycle after a pop grant -> o_rsp_vld = 0 immediately. After release, the first grant goes to Req0 when all four request.

Source files
------------

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter that lets NREQ requesters share one LIFO stack.
// One push or pop is granted per cycle; the response is registered one cycle later.
module stack_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               areset,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_op,
    input  logic [NREQ*DW-1:0] i_wdata,
    output logic [NREQ-1:0]    o_gnt,
    output logic [NREQ-1:0]    o_rsp_vld,
    output logic               o_rsp_err,
    output logic [DW-1:0]      o_rsp_data,
    output logic               o_stk_push_en,
    output logic [DW-1:0]      o_stk_push_data,
    output logic               o_stk_pop_en,
    input  logic [DW-1:0]      i_stk_pop_data,
    input  logic               i_stk_full,
    input  logic               i_stk_empty
);
    localparam int          IW     = $clog2(NREQ);
    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    logic [IW-1:0] last_gnt_ff;
    logic [IW-1:0] win;
    logic          found;
    logic          op_push;
    logic          push_ok;
    logic          pop_ok;
    logic [DW-1:0] wdata_arr [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_wdata
        assign wdata_arr[k] = i_wdata[k*DW +: DW];
    end

    // Search starts just after the last winner and wraps, so the last winner is checked last.
    always_comb begin
        logic [IW:0] cand;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last_gnt_ff} + (IW+1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && i_req[cand[IW-1:0]]) begin
                found = 1'b1;
                win   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        o_gnt = '0;
        if (found) begin
            o_gnt[win] = 1'b1;
        end
    end

    // Rejected operations still consume a grant but never touch the stack.
    assign op_push         = i_op[win];
    assign push_ok         = found & op_push & ~i_stk_full;
    assign pop_ok          = found & ~op_push & ~i_stk_empty;
    assign o_stk_push_en   = push_ok;
    assign o_stk_pop_en    = pop_ok;
    assign o_stk_push_data = push_ok ? wdata_arr[win] : '0;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            last_gnt_ff <= IW'(NREQ-1);
            o_rsp_vld   <= '0;
            o_rsp_err   <= 1'b0;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_vld <= o_gnt;
            o_rsp_err <= found & ~push_ok & ~pop_ok;
            if (found) begin
                last_gnt_ff <= win;
            end
            if (pop_ok) begin
                o_rsp_data <= i_stk_pop_data;
            end
        end
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// Testbench for stack_arbiter: directed scenarios then random traffic against a
// queue-based reference of the arbiter plus a 4-deep behavioural stack.
module tb_stack_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               areset;
    logic [NREQ-1:0]    i_req;
    logic [NREQ-1:0]    i_op;
    logic [NREQ*DW-1:0] i_wdata;
    logic [NREQ-1:0]    o_gnt;
    logic [NREQ-1:0]    o_rsp_vld;
    logic               o_rsp_err;
    logic [DW-1:0]      o_rsp_data;
    logic               o_stk_push_en;
    logic [DW-1:0]      o_stk_push_data;
    logic               o_stk_pop_en;
    logic [DW-1:0]      i_stk_pop_data;
    logic               i_stk_full;
    logic               i_stk_empty;

    int total = 0;
    int bad   = 0;

    stack_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk(clk), .areset(areset),
        .i_req(i_req), .i_op(i_op), .i_wdata(i_wdata),
        .o_gnt(o_gnt), .o_rsp_vld(o_rsp_vld), .o_rsp_err(o_rsp_err), .o_rsp_data(o_rsp_data),
        .o_stk_push_en(o_stk_push_en), .o_stk_push_data(o_stk_push_data),
        .o_stk_pop_en(o_stk_pop_en), .i_stk_pop_data(i_stk_pop_data),
        .i_stk_full(i_stk_full), .i_stk_empty(i_stk_empty)
    );

    always #5 clk = ~clk;

    // Physical stack driven by the DUT enables; not reset by the arbiter's reset.
    logic [DW-1:0] mem [DEPTH];
    int            cnt = 0;

    always @(posedge clk) begin
        if (o_stk_push_en && cnt < DEPTH) begin
            mem[cnt] <= o_stk_push_data;
            cnt      <= cnt + 1;
        end else if (o_stk_pop_en && cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    always_comb begin
        i_stk_full     = (cnt == DEPTH);
        i_stk_empty    = (cnt == 0);
        i_stk_pop_data = (cnt > 0) ? mem[cnt-1] : '0;
    end

    // Reference state: last winner index, expected stack contents, expected response data.
    int            last_m = NREQ - 1;
    logic [DW-1:0] ref_q[$];
    logic [DW-1:0] exp_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic cycle(input logic [NREQ-1:0] req, input logic [NREQ-1:0] op,
                         input logic [NREQ*DW-1:0] wd, output int gw);
        int            w;
        int            k;
        logic [NREQ-1:0] eg;
        logic          epush;
        logic          epop;
        logic [DW-1:0] epd;
        logic          ne;
        i_req   = req;
        i_op    = op;
        i_wdata = wd;
        #4;
        w = -1;
        for (int i = 1; i <= NREQ; i++) begin
            k = (last_m + i) % NREQ;
            if (w < 0 && req[k]) w = k;
        end
        eg = '0; epush = 1'b0; epop = 1'b0; epd = '0; ne = 1'b0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            if (op[w]) begin
                if (ref_q.size() < DEPTH) begin
                    epush = 1'b1;
                    epd   = wd[w*DW +: DW];
                    ref_q.push_back(epd);
                end else begin
                    ne = 1'b1;
                end
            end else begin
                if (ref_q.size() > 0) begin
                    epop     = 1'b1;
                    exp_data = ref_q.pop_back();
                end else begin
                    ne = 1'b1;
                end
            end
            last_m = w;
        end
        chk("gnt", 32'(o_gnt), 32'(eg));
        chk("push_en", 32'(o_stk_push_en), 32'(epush));
        chk("push_data", 32'(o_stk_push_data), 32'(epd));
        chk("pop_en", 32'(o_stk_pop_en), 32'(epop));
        @(posedge clk);
        #1;
        chk("rsp_vld", 32'(o_rsp_vld), 32'(eg));
        chk("rsp_err", 32'(o_rsp_err), 32'(ne));
        chk("rsp_data", 32'(o_rsp_data), 32'(exp_data));
        gw = w;
    endtask

    logic [NREQ-1:0]    pend;
    logic [NREQ-1:0]    pop_op;
    logic [NREQ*DW-1:0] pdata;

    initial begin
        int g;
        areset  = 1'b1;
        i_req   = '0;
        i_op    = '0;
        i_wdata = '0;
        #2;
        chk("rst_gnt", 32'(o_gnt), 32'h0);
        chk("rst_rsp_vld", 32'(o_rsp_vld), 32'h0);
        chk("rst_rsp_err", 32'(o_rsp_err), 32'h0);
        chk("rst_rsp_data", 32'(o_rsp_data), 32'h0);
        chk("rst_push_en", 32'(o_stk_push_en), 32'h0);
        chk("rst_pop_en", 32'(o_stk_pop_en), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Two pushes, then two pops returning them in LIFO order.
        cycle(4'b0001, 4'b0001, 32'h000000A1, g);
        cycle(4'b0010, 4'b0010, 32'h0000B200, g);
        cycle(4'b0100, 4'b0000, 32'h0, g);
        cycle(4'b1000, 4'b0000, 32'h0, g);

        // Everyone pops an empty stack: rotation 0,1,2,3,0, all rejected.
        for (int i = 0; i < 5; i++) cycle(4'b1111, 4'b0000, 32'h0, g);

        // Fill the stack, then a push to a full stack is rejected.
        cycle(4'b0010, 4'b0010, 32'h00001100, g);
        cycle(4'b0100, 4'b0100, 32'h00220000, g);
        cycle(4'b1000, 4'b1000, 32'h33000000, g);
        cycle(4'b0001, 4'b0001, 32'h00000044, g);
        cycle(4'b1000, 4'b1000, 32'h55000000, g);
        cycle(4'b0001, 4'b0000, 32'h0, g);

        // Pop grant, then reset lands while its response is visible.
        cycle(4'b0010, 4'b0000, 32'h0, g);
        i_req  = '0;
        areset = 1'b1;
        #1;
        chk("rst_mid_rsp_vld", 32'(o_rsp_vld), 32'h0);
        chk("rst_mid_rsp_err", 32'(o_rsp_err), 32'h0);
        last_m   = NREQ - 1;
        exp_data = '0;
        @(posedge clk);
        #1;
        areset = 1'b0;
        for (int i = 0; i < 4; i++) cycle(4'b1111, 4'b0000, 32'h0, g);

        // Random traffic; each request is held until it is granted.
        pend   = '0;
        pop_op = '0;
        pdata  = '0;
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!pend[k] && $urandom_range(0, 2) != 0) begin
                    pend[k]            = 1'b1;
                    pop_op[k]          = 1'($urandom_range(0, 1));
                    pdata[k*DW +: DW]  = DW'($urandom);
                end
            end
            cycle(pend, pop_op, pdata, g);
            if (g >= 0) pend[g] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
